instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Instruction fetch stage sitting directly downstream of the PC register.
- Consumes the current PC and PC+4, issues one instruction-memory read per PC and advances the PC.
- Applies branch/jump redirects from later stages.
- Presents fetched instructions to decode over a valid/ready handshake.
- At most one memory request outstanding; one-entry output buffer.

Parameters:
ADDR_WIDTH, 24, width of PC and memory address
INSTR_WIDTH, 32, width of an instruction word

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous active-low reset
pc  input  ADDR_WIDTH  current PC from PC register
pc_plus_4  input  ADDR_WIDTH  current PC + 4 from PC register
pc_load_en  output  1  PC register load enable
pc_next  output  ADDR_WIDTH  value to load into PC register
imem_req_valid  output  1  memory read request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  ADDR_WIDTH  read address
imem_rsp_valid  input  1  read data valid (1-cycle pulse)
imem_rsp_data  input  INSTR_WIDTH  read data
redirect_valid  input  1  redirect request from execute
redirect_addr  input  ADDR_WIDTH  redirect target
if_valid  output  1  instruction available to decode
if_ready  input  1  decode accepts instruction
if_instr  output  INSTR_WIDTH  fetched instruction
if_pc  output  ADDR_WIDTH  PC of if_instr
if_pc_plus_4  output  ADDR_WIDTH  PC+4 of if_instr

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to REQ.
  - if_valid=0; if_instr, if_pc, if_pc_plus_4 = 0.
  - kill flag = 0.
  - pc_load_en and imem_req_valid are forced to 0 while reset is low.
- Reset mid-operation: the outstanding request is abandoned. Any response arriving in the first REQ state after reset is ignored.
- FSM states: REQ, WAIT, OUT.
- REQ:
  - imem_req_valid = !redirect_valid; imem_req_addr = pc.
  - Handshake (valid & ready): capture pc and pc_plus_4 into pending registers; pc_load_en=1 and pc_next=pc_plus_4 in the same cycle; next state WAIT.
  - No handshake: remain in REQ.
- WAIT:
  - imem_rsp_valid & !kill & !redirect_valid: latch if_instr=imem_rsp_data and if_pc/if_pc_plus_4 from the pending registers; if_valid=1 next cycle; next state OUT.
  - imem_rsp_valid & (kill | redirect_valid): discard data, clear kill, next state REQ.
  - No response: remain in WAIT.
- OUT:
  - if_valid & if_ready: if_valid=0 next cycle, next state REQ.
  - Otherwise hold all if_* outputs stable.
- Redirect (redirect_valid=1), in any state:
  - pc_load_en=1 and pc_next = {redirect_addr[ADDR_WIDTH-1:2], 2'b00}.
  - Redirect has priority over the sequential PC+4 load.
  - In REQ: no request is issued that cycle; stay in REQ.
  - In WAIT without a response that cycle: set kill and stay in WAIT.
  - In OUT: if_valid=0 next cycle (buffered instruction dropped, even if if_ready=1 that cycle); next state REQ.
- pc_load_en=0 in all other cycles. pc_next=pc_plus_4 when not loading.
- imem_rsp_valid in REQ or OUT is ignored (no state change).
- Arithmetic:
  - No addition inside this block; PC+4 is taken from the pc_plus_4 input.
  - Address wrap-around at 2^ADDR_WIDTH is inherited from the PC register and needs no special handling.
- Throughput: best case one instruction per 3 cycles (REQ, WAIT with same-cycle response in the next cycle, OUT with if_ready=1).
- if_* outputs are registered. Request outputs and pc_load_en are combinational from state and inputs.

Test Plan:
- Sequential fetch: reset release with pc=0x000000, memory always ready, 1-cycle latency returning 0x00000013 then 0x00100093 → if_pc 0x000000 then 0x000004; pc_load_en pulses with pc_next=0x000004, then 0x000008.
- Decode stall: hold if_ready=0 for 5 cycles with if_valid=1 → if_instr/if_pc stable; no new imem_req_valid; release → REQ next cycle.
- Redirect in WAIT: redirect_addr=0x000103 while awaiting response for pc 0x000010 → pc_next=0x000100; returned data discarded (if_valid stays 0); next request address 0x000100.
- Redirect in OUT with if_ready=1 same cycle: buffered instruction dropped; next if_pc=redirect target.
- Memory backpressure: imem_req_ready=0 for 4 cycles → imem_req_valid held with constant address, pc_load_en=0 throughout, advances only on accept.
- Async reset asserted in WAIT mid-cycle → outputs zero immediately without a clock edge; a stale response after reset release does not raise if_valid.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage.
// Sits directly after the PC register. It reads the current PC, issues one
// instruction-memory read per PC, and advances the PC register through
// pc_load_en/pc_next. Branch and jump redirects from execute are applied here.
// The fetched word is handed to decode through a one-entry valid/ready buffer.
// Only one memory request is ever outstanding. A redirect that arrives while a
// read is in flight marks that read as stale (the kill flag). When the stale
// response comes back, it is dropped.

module instr_fetch #(
  parameter int ADDR_WIDTH  = 24,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,

  // PC register interface
  input  logic [ADDR_WIDTH-1:0]  pc,
  input  logic [ADDR_WIDTH-1:0]  pc_plus_4,
  output logic                   pc_load_en,
  output logic [ADDR_WIDTH-1:0]  pc_next,

  // Instruction memory request channel
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,

  // Instruction memory response (single-cycle pulse)
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,

  // Redirect from execute
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr,

  // Decode interface
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0]  if_pc,
  output logic [ADDR_WIDTH-1:0]  if_pc_plus_4
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // issue a read for the current PC
    S_WAIT = 2'd1,  // read accepted, waiting for the response pulse
    S_OUT  = 2'd2   // instruction buffered, waiting for decode
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    kill;
  logic                    kill_next;

  // PC and PC+4 of the read that is in flight
  logic [ADDR_WIDTH-1:0]   pend_pc;
  logic [ADDR_WIDTH-1:0]   pend_pc_plus_4;

  // One-cycle control strobes produced by the next-state logic
  logic                    req_fire;
  logic                    out_load;
  logic                    out_clear;

  // Redirect targets are forced to word alignment
  logic [ADDR_WIDTH-1:0]   redirect_target;

  assign redirect_target = {redirect_addr[ADDR_WIDTH-1:2], 2'b00};

  // The read address is always the current PC. It only has meaning while
  // imem_req_valid is high.
  assign imem_req_addr = pc;

  // Next-state logic plus the combinational request and PC-load outputs
  always_comb begin
    // NOTE: every signal written in this block gets a default first. That way
    // no path through the case statement leaves one unassigned and infers a latch.
    state_next     = state;
    kill_next      = kill;
    req_fire       = 1'b0;
    out_load       = 1'b0;
    out_clear      = 1'b0;
    imem_req_valid = 1'b0;
    pc_load_en     = 1'b0;
    pc_next        = pc_plus_4;

    unique case (state)
      S_REQ: begin
        // A redirect in this cycle means pc is about to change, so hold off
        // the read until the new PC is in place.
        imem_req_valid = !redirect_valid;
        req_fire       = !redirect_valid && imem_req_ready;
        if (req_fire) begin
          pc_load_en = 1'b1;
          state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (!kill && !redirect_valid) begin
            out_load   = 1'b1;
            state_next = S_OUT;
          end else begin
            // Stale response: drop it and start fetching from the new PC
            kill_next  = 1'b0;
            state_next = S_REQ;
          end
        end else if (redirect_valid) begin
          // The read still in flight belongs to the old path
          kill_next = 1'b1;
        end
      end

      S_OUT: begin
        // A redirect drops the buffered instruction even if decode is taking
        // it in this same cycle.
        if (redirect_valid || if_ready) begin
          out_clear  = 1'b1;
          state_next = S_REQ;
        end
      end

      default: begin
        state_next = S_REQ;
        kill_next  = 1'b0;
      end
    endcase

    // A redirect wins over the sequential PC+4 advance in every state
    if (redirect_valid) begin
      pc_load_en = 1'b1;
      pc_next    = redirect_target;
    end

    // While reset is held, nothing may touch memory or the PC register
    if (!reset) begin
      imem_req_valid = 1'b0;
      pc_load_en     = 1'b0;
    end
  end

  // State register and kill flag
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only. Every register
    // then updates from values sampled before the edge, whatever order the
    // blocks run in.
    if (!reset) begin
      state <= S_REQ;
      kill  <= 1'b0;
    end else begin
      state <= state_next;
      kill  <= kill_next;
    end
  end

  // Remember which PC the outstanding read belongs to
  always_ff @(posedge clk) begin
    // NOTE: these are pure datapath registers with no reset. They are written
    // on every accepted request before anything reads them.
    if (req_fire) begin
      pend_pc        <= pc;
      pend_pc_plus_4 <= pc_plus_4;
    end
  end

  // Registered decode-side buffer: fill on a good response, hold while
  // stalled, empty on accept or redirect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_valid     <= 1'b0;
      if_instr     <= '0;
      if_pc        <= '0;
      if_pc_plus_4 <= '0;
    end else if (out_load) begin
      if_valid     <= 1'b1;
      if_instr     <= imem_rsp_data;
      if_pc        <= pend_pc;
      if_pc_plus_4 <= pend_pc_plus_4;
    end else if (out_clear) begin
      if_valid     <= 1'b0;
    end
  end

  // The buffer is full exactly when the FSM is in S_OUT
  assert property (@(posedge clk) disable iff (!reset)
    if_valid == (state == S_OUT));

  // A read is only ever marked stale while it is in flight
  assert property (@(posedge clk) disable iff (!reset)
    kill |-> (state == S_WAIT));

  // Without a redirect, the PC only advances when a request is accepted
  assert property (@(posedge clk) disable iff (!reset)
    (pc_load_en && !redirect_valid) |-> req_fire);

  // Redirected PCs are always word aligned
  assert property (@(posedge clk) disable iff (!reset)
    redirect_valid |-> (pc_load_en && pc_next[1:0] == 2'b00));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch.
// The bench models the PC register that drives pc/pc_plus_4. Inputs change
// just after the falling edge, and outputs are sampled 1 ns later, well away
// from the rising edge.

module tb_instr_fetch;

  localparam int AW = 24;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_plus_4;
  logic          pc_load_en;
  logic [AW-1:0] pc_next;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [IW-1:0] imem_rsp_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          if_valid;
  logic          if_ready;
  logic [IW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic [AW-1:0] if_pc_plus_4;

  int checks = 0;
  int passed = 0;

  instr_fetch #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .pc_plus_4      (pc_plus_4),
    .pc_load_en     (pc_load_en),
    .pc_next        (pc_next),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus_4   (if_pc_plus_4)
  );

  always #5 clk = ~clk;

  // PC register model
  always @(posedge clk or negedge reset) begin
    if (!reset)          pc <= '0;
    else if (pc_load_en) pc <= pc_next;
  end
  assign pc_plus_4 = pc + 24'd4;

  // Advance to the next falling edge, one full cycle later
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_addr = '0; if_ready = 1'b0;
    @(negedge clk); #1;
    checks++; if (if_valid !== 1'b0) $display("FAIL reset_if_valid got %0h exp 0", if_valid); else passed++;
    checks++; if (if_instr !== 32'h0) $display("FAIL reset_if_instr got %0h exp 0", if_instr); else passed++;
    checks++; if (if_pc !== 24'h0) $display("FAIL reset_if_pc got %0h exp 0", if_pc); else passed++;
    checks++; if (if_pc_plus_4 !== 24'h0) $display("FAIL reset_if_pc_plus_4 got %0h exp 0", if_pc_plus_4); else passed++;
    checks++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid got %0h exp 0", imem_req_valid); else passed++;
    checks++; if (pc_load_en !== 1'b0) $display("FAIL reset_pc_load_en got %0h exp 0", pc_load_en); else passed++;
    tick(); reset = 1'b1; #1;
    checks++; if (imem_req_valid !== 1'b1) $display("FAIL first_req_valid got %0h exp 1", imem_req_valid); else passed++;
    checks++; if (imem_req_addr !== 24'h0) $display("FAIL first_req_addr got %0h exp 0", imem_req_addr); else passed++;
    checks++; if (pc_load_en !== 1'b1) $display("FAIL first_pc_load_en got %0h exp 1", pc_load_en); else passed++;
    checks++; if (pc_next !== 24'h4) $display("FAIL first_pc_next got %0h exp 4", pc_next); else passed++;
  endtask

  task automatic test_sequential();
    tick(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013; #1;  // WAIT
    checks++; if (imem_req_valid !== 1'b0) $display("FAIL seq_wait_req_valid got %0h exp 0", imem_req_valid); else passed++;
    checks++; if (pc_load_en !== 1'b0) $display("FAIL seq_wait_pc_load_en got %0h exp 0", pc_load_en); else passed++;
    checks++; if (pc_next !== 24'h8) $display("FAIL seq_wait_pc_next got %0h exp 8", pc_next); else passed++;
    tick(); imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b1; #1;  // OUT
    checks++; if (if_valid !== 1'b1) $display("FAIL seq0_if_valid got %0h exp 1", if_valid); else passed++;
    checks++; if (if_instr !== 32'h0000_0013) $display("FAIL seq0_if_instr got %0h exp 13", if_instr); else passed++;
    checks++; if (if_pc !== 24'h0) $display("FAIL seq0_if_pc got %0h exp 0", if_pc); else passed++;
    checks++; if (if_pc_plus_4 !== 24'h4) $display("FAIL seq0_if_pc_plus_4 got %0h exp 4", if_pc_plus_4); else passed++;
    tick(); if_ready = 1'b0; #1;  // REQ
    checks++; if (if_valid !== 1'b0) $display("FAIL seq1_req_if_valid got %0h exp 0", if_valid); else passed++;
    checks++; if (imem_req_addr !== 24'h4) $display("FAIL seq1_req_addr got %0h exp 4", imem_req_addr); else passed++;
    checks++; if (pc_load_en !== 1'b1) $display("FAIL seq1_pc_load_en got %0h exp 1", pc_load_en); else passed++;
    checks++; if (pc_next !== 24'h8) $display("FAIL seq1_pc_next got %0h exp 8", pc_next); else passed++;
    tick(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;  // WAIT
    tick(); imem_rsp_valid = 1'b0; imem_rsp_data = '0; #1;  // OUT
    checks++; if (if_instr !== 32'h0010_0093) $display("FAIL seq1_if_instr got %0h exp 100093", if_instr); else passed++;
    checks++; if (if_pc !== 24'h4) $display("FAIL seq1_if_pc got %0h exp 4", if_pc); else passed++;
    checks++; if (if_pc_plus_4 !== 24'h8) $display("FAIL seq1_if_pc_plus_4 got %0h exp 8", if_pc_plus_4); else passed++;
  endtask

  task automatic test_decode_stall();
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      checks++; if (if_valid !== 1'b1) $display("FAIL stall%0d_if_valid got %0h exp 1", i, if_valid); else passed++;
      checks++; if (if_instr !== 32'h0010_0093) $display("FAIL stall%0d_if_instr got %0h exp 100093", i, if_instr); else passed++;
      checks++; if (if_pc !== 24'h4) $display("FAIL stall%0d_if_pc got %0h exp 4", i, if_pc); else passed++;
      checks++; if (imem_req_valid !== 1'b0) $display("FAIL stall%0d_req_valid got %0h exp 0", i, imem_req_valid); else passed++;
      checks++; if (pc_load_en !== 1'b0) $display("FAIL stall%0d_pc_load_en got %0h exp 0", i, pc_load_en); else passed++;
    end
    if_ready = 1'b1;
    tick(); if_ready = 1'b0; #1;  // REQ
    checks++; if (if_valid !== 1'b0) $display("FAIL stall_release_if_valid got %0h exp 0", if_valid); else passed++;
    checks++; if (imem_req_valid !== 1'b1) $display("FAIL stall_release_req_valid got %0h exp 1", imem_req_valid); else passed++;
    checks++; if (imem_req_addr !== 24'h8) $display("FAIL stall_release_req_addr got %0h exp 8", imem_req_addr); else passed++;
  endtask

  task automatic test_redirect_wait();
    // Redirect while in REQ to move the PC to 0x10; no request that cycle
    redirect_valid = 1'b1; redirect_addr = 24'h000010; #1;
    checks++; if (imem_req_valid !== 1'b0) $display("FAIL rdreq_req_valid got %0h exp 0", imem_req_valid); else passed++;
    checks++; if (pc_load_en !== 1'b1) $display("FAIL rdreq_pc_load_en got %0h exp 1", pc_load_en); else passed++;
    checks++; if (pc_next !== 24'h10) $display("FAIL rdreq_pc_next got %0h exp 10", pc_next); else passed++;
    tick(); redirect_valid = 1'b0; #1;  // still REQ, pc = 0x10
    checks++; if (imem_req_addr !== 24'h10) $display("FAIL rdwait_req_addr got %0h exp 10", imem_req_addr); else passed++;
    tick(); redirect_valid = 1'b1; redirect_addr = 24'h000103; #1;  // WAIT for 0x10
    checks++; if (pc_load_en !== 1'b1) $display("FAIL rdwait_pc_load_en got %0h exp 1", pc_load_en); else passed++;
    checks++; if (pc_next !== 24'h100) $display("FAIL rdwait_pc_next got %0h exp 100", pc_next); else passed++;
    tick(); redirect_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; #1;
    checks++; if (pc_load_en !== 1'b0) $display("FAIL rdwait_killed_pc_load_en got %0h exp 0", pc_load_en); else passed++;
    tick(); imem_rsp_valid = 1'b0; imem_rsp_data = '0; #1;  // back in REQ
    checks++; if (if_valid !== 1'b0) $display("FAIL rdwait_if_valid got %0h exp 0", if_valid); else passed++;
    checks++; if (imem_req_valid !== 1'b1) $display("FAIL rdwait_next_req_valid got %0h exp 1", imem_req_valid); else passed++;
    checks++; if (imem_req_addr !== 24'h100) $display("FAIL rdwait_next_req_addr got %0h exp 100", imem_req_addr); else passed++;
  endtask

  task automatic test_redirect_out();
    tick(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE_F00D;  // WAIT for 0x100
    tick(); imem_rsp_valid = 1'b0; imem_rsp_data = '0; #1;  // OUT
    checks++; if (if_pc !== 24'h100) $display("FAIL rdout_buffered_if_pc got %0h exp 100", if_pc); else passed++;
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_addr = 24'h000200; #1;
    checks++; if (pc_next !== 24'h200) $display("FAIL rdout_pc_next got %0h exp 200", pc_next); else passed++;
    tick(); redirect_valid = 1'b0; if_ready = 1'b0; #1;  // REQ at 0x200
    checks++; if (if_valid !== 1'b0) $display("FAIL rdout_dropped_if_valid got %0h exp 0", if_valid); else passed++;
    checks++; if (imem_req_addr !== 24'h200) $display("FAIL rdout_req_addr got %0h exp 200", imem_req_addr); else passed++;
    tick(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0020_0113;  // WAIT
    tick(); imem_rsp_valid = 1'b0; imem_rsp_data = '0; #1;  // OUT
    checks++; if (if_instr !== 32'h0020_0113) $display("FAIL rdout_if_instr got %0h exp 200113", if_instr); else passed++;
    checks++; if (if_pc !== 24'h200) $display("FAIL rdout_if_pc got %0h exp 200", if_pc); else passed++;
    checks++; if (if_pc_plus_4 !== 24'h204) $display("FAIL rdout_if_pc_plus_4 got %0h exp 204", if_pc_plus_4); else passed++;
    if_ready = 1'b1;
    tick(); if_ready = 1'b0;  // REQ at 0x204
  endtask

  task automatic test_backpressure();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (imem_req_valid !== 1'b1) $display("FAIL bp%0d_req_valid got %0h exp 1", i, imem_req_valid); else passed++;
      checks++; if (imem_req_addr !== 24'h204) $display("FAIL bp%0d_req_addr got %0h exp 204", i, imem_req_addr); else passed++;
      checks++; if (pc_load_en !== 1'b0) $display("FAIL bp%0d_pc_load_en got %0h exp 0", i, pc_load_en); else passed++;
      tick();
    end
    imem_req_ready = 1'b1; #1;
    checks++; if (pc_load_en !== 1'b1) $display("FAIL bp_accept_pc_load_en got %0h exp 1", pc_load_en); else passed++;
    checks++; if (pc_next !== 24'h208) $display("FAIL bp_accept_pc_next got %0h exp 208", pc_next); else passed++;
    tick();  // WAIT for 0x204
  endtask

  task automatic test_async_reset();
    #2; reset = 1'b0; #1;  // mid-cycle, no clock edge in between
    checks++; if (if_pc !== 24'h0) $display("FAIL areset_if_pc got %0h exp 0", if_pc); else passed++;
    checks++; if (if_pc_plus_4 !== 24'h0) $display("FAIL areset_if_pc_plus_4 got %0h exp 0", if_pc_plus_4); else passed++;
    checks++; if (if_instr !== 32'h0) $display("FAIL areset_if_instr got %0h exp 0", if_instr); else passed++;
    checks++; if (imem_req_valid !== 1'b0) $display("FAIL areset_req_valid got %0h exp 0", imem_req_valid); else passed++;
    checks++; if (pc_load_en !== 1'b0) $display("FAIL areset_pc_load_en got %0h exp 0", pc_load_en); else passed++;
    tick(); tick();
    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0BAD_0BAD; #1;
    checks++; if (imem_req_addr !== 24'h0) $display("FAIL areset_req_addr got %0h exp 0", imem_req_addr); else passed++;
    tick(); imem_rsp_valid = 1'b0; imem_rsp_data = '0; #1;
    checks++; if (if_valid !== 1'b0) $display("FAIL areset_stale_if_valid got %0h exp 0", if_valid); else passed++;
    checks++; if (imem_req_valid !== 1'b1) $display("FAIL areset_still_req got %0h exp 1", imem_req_valid); else passed++;
    imem_req_ready = 1'b1;
    tick(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;  // WAIT
    tick(); imem_rsp_valid = 1'b0; imem_rsp_data = '0; #1;  // OUT
    checks++; if (if_valid !== 1'b1) $display("FAIL areset_recover_if_valid got %0h exp 1", if_valid); else passed++;
    checks++; if (if_pc !== 24'h0) $display("FAIL areset_recover_if_pc got %0h exp 0", if_pc); else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_decode_stall();
    test_redirect_wait();
    test_redirect_out();
    test_backpressure();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
